// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding and PC arithmetic constants.
package fetch_unit_pkg;
   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_e;

   localparam int PC_STEP    = 4;
   localparam int WORD_SHIFT = 2;
endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory and fetch-to-decode bus for the fetch stage.
interface fetch_unit_if #(
   parameter int n = 64
);
   logic [n-1:0] imem_addr;
   logic [n-1:0] imem_data;
   logic [n-1:0] if_id_pc;
   logic [n-1:0] if_id_instr;
   logic         if_id_valid;
   logic         id_ready;

   modport master (
      output imem_addr,
      input  imem_data,
      output if_id_pc,
      output if_id_instr,
      output if_id_valid,
      input  id_ready
   );

   modport slave (
      input  imem_addr,
      output imem_data,
      input  if_id_pc,
      input  if_id_instr,
      input  if_id_valid,
      output id_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the 1-cycle-latency instruction memory,
// pairs each returned word with its PC and hands it to decode with stall/redirect/halt.
//
// state | meaning
// RUN   | fetching; one word per cycle when decode is ready
// HALT  | halt word accepted by decode; idle until a branch redirect
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int           n          = 64,
   parameter logic [n-1:0] RESET_PC   = '0,
   parameter logic [n-1:0] HALT_INSTR = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          branch_taken,
   input  logic [n-1:0]  branch_target,
   fetch_unit_if.master  bus,
   output logic          halted,
   output logic [31:0]   fetch_count
);

   fetch_state_e state;
   logic [n-1:0] fetch_pc;
   logic [n-1:0] resp_pc;
   logic         resp_valid;

   logic [n-1:0] target_al;
   logic [n-1:0] sel_pc;
   logic         stall;
   logic         accept;

   assign target_al = branch_target & ~{{(n-2){1'b0}}, 2'b11};
   assign stall     = resp_valid && !bus.id_ready;

   assign bus.if_id_pc    = resp_pc;
   assign bus.if_id_instr = bus.imem_data;
   assign bus.if_id_valid = resp_valid && (state == RUN) && !branch_taken;
   assign accept          = bus.if_id_valid && bus.id_ready;
   assign halted          = (state == HALT);

   // On a stall the held word is re-read so imem_data keeps presenting it.
   always_comb begin
      sel_pc = fetch_pc;
      if (branch_taken)
         sel_pc = target_al;
      else if (state == RUN && stall)
         sel_pc = resp_pc;
   end

   assign bus.imem_addr = sel_pc >> WORD_SHIFT;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= RUN;
         fetch_pc    <= RESET_PC;
         resp_pc     <= '0;
         resp_valid  <= 1'b0;
         fetch_count <= '0;
      end else if (branch_taken) begin
         state      <= RUN;
         resp_pc    <= target_al;
         resp_valid <= 1'b1;
         fetch_pc   <= target_al + n'(PC_STEP);
      end else if (state == RUN && !stall) begin
         resp_pc    <= fetch_pc;
         resp_valid <= 1'b1;
         fetch_pc   <= fetch_pc + n'(PC_STEP);
         if (accept) begin
            fetch_count <= fetch_count + 32'd1;
            // The halt word itself is delivered and counted before stopping.
            if (bus.imem_data == HALT_INSTR) begin
               state      <= HALT;
               resp_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by randomized
// ready/redirect traffic against a stream-level reference model.
module tb_fetch_unit;
   localparam int          N      = 64;
   localparam logic [63:0] HALT_W = 64'hFFFF_0000_0000_0001;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        branch_taken = 1'b0;
   logic [63:0] branch_target = '0;
   logic        halted;
   logic [31:0] fetch_count;
   logic [63:0] mem [256];

   int n_assert = 0;
   int n_fail   = 0;

   fetch_unit_if #(.n(N)) bus ();

   fetch_unit #(
      .n(N),
      .RESET_PC(64'h0),
      .HALT_INSTR(HALT_W)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .branch_taken(branch_taken),
      .branch_target(branch_target),
      .bus(bus),
      .halted(halted),
      .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) bus.imem_data <= mem[8'(bus.imem_addr % 64'd256)];

   function automatic logic [63:0] mem_word(input logic [63:0] pc);
      return mem[8'((pc >> 2) % 64'd256)];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      branch_taken = 1'b0;
      bus.id_ready = 1'b1;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic chk_out(input string tag, input logic [63:0] pc);
      chk({tag, "_valid"}, 64'(bus.if_id_valid), 64'd1);
      chk({tag, "_pc"}, bus.if_id_pc, pc);
      chk({tag, "_instr"}, bus.if_id_instr, mem_word(pc));
   endtask

   logic [63:0] m_pc;
   logic [63:0] tgt;
   logic [31:0] m_count;
   bit          m_valid, m_halt, br, rdy, exp_v;

   initial begin
      for (int i = 0; i < 256; i++)
         mem[i] = {32'hC0DE_0000 + 32'(i), 32'h5A5A_0000 + 32'(i)};
      bus.id_ready = 1'b1;

      // Reset values
      rst_n = 1'b0;
      tick();
      tick();
      #2;
      chk("rst_valid", 64'(bus.if_id_valid), 64'd0);
      chk("rst_halted", 64'(halted), 64'd0);
      chk("rst_pc", bus.if_id_pc, 64'd0);
      chk("rst_count", 64'(fetch_count), 64'd0);
      tick();
      rst_n = 1'b1;
      #2;
      chk("release_valid", 64'(bus.if_id_valid), 64'd0);
      tick();

      // Straight-line fetch (0,A) (4,B) (8,C) (12,D)
      for (int i = 0; i < 4; i++) begin
         #2;
         chk_out("seq", 64'(4 * i));
         tick();
      end
      chk("seq_count", 64'(fetch_count), 64'd4);

      // Stall while (4,B) is presented
      do_reset();
      tick();
      tick();
      bus.id_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #2;
         chk("stall_addr", bus.imem_addr, 64'd1);
         chk_out("stall", 64'd4);
         tick();
      end
      bus.id_ready = 1'b1;
      #2;
      chk_out("stall_rel", 64'd4);
      tick();
      #2;
      chk_out("after_stall", 64'd8);
      chk("after_stall_count", 64'(fetch_count), 64'd2);

      // Redirect while (8,C) is presented
      branch_taken  = 1'b1;
      branch_target = 64'h40;
      #1;
      chk("br_valid", 64'(bus.if_id_valid), 64'd0);
      chk("br_addr", bus.imem_addr, 64'h10);
      tick();
      branch_taken = 1'b0;
      #2;
      chk_out("br_tgt", 64'h40);
      chk("br_count", 64'(fetch_count), 64'd2);

      // Redirect and stall together; low target bits ignored
      do_reset();
      tick();
      tick();
      tick();
      bus.id_ready  = 1'b0;
      branch_taken  = 1'b1;
      branch_target = 64'h43;
      #2;
      chk("brst_valid", 64'(bus.if_id_valid), 64'd0);
      chk("brst_addr", bus.imem_addr, 64'h10);
      tick();
      branch_taken = 1'b0;
      bus.id_ready = 1'b1;
      #2;
      chk_out("brst_tgt", 64'h40);
      chk("brst_count", 64'(fetch_count), 64'd2);
      tick();
      #2;
      chk_out("brst_next", 64'h44);

      // Halt word at address 8
      mem[2] = HALT_W;
      do_reset();
      tick();
      tick();
      tick();
      #2;
      chk_out("halt_word", 64'd8);
      tick();
      for (int i = 0; i < 5; i++) begin
         #2;
         chk("halt_halted", 64'(halted), 64'd1);
         chk("halt_valid", 64'(bus.if_id_valid), 64'd0);
         tick();
      end
      chk("halt_count", 64'(fetch_count), 64'd3);
      branch_taken  = 1'b1;
      branch_target = 64'h0;
      #2;
      chk("halt_br_addr", bus.imem_addr, 64'd0);
      chk("halt_br_valid", 64'(bus.if_id_valid), 64'd0);
      tick();
      branch_taken = 1'b0;
      #2;
      chk("resume_halted", 64'(halted), 64'd0);
      chk_out("resume", 64'd0);
      mem[2] = {32'hC0DE_0002, 32'h5A5A_0002};
      tick();
      tick();

      // Reset asserted mid-run clears only at the edge
      rst_n = 1'b0;
      #2;
      chk("midrst_valid_pre", 64'(bus.if_id_valid), 64'd1);
      chk("midrst_count_pre", 64'(fetch_count), 64'd5);
      tick();
      chk("midrst_valid", 64'(bus.if_id_valid), 64'd0);
      chk("midrst_pc", bus.if_id_pc, 64'd0);
      chk("midrst_count", 64'(fetch_count), 64'd0);
      rst_n = 1'b1;
      tick();
      #2;
      chk_out("midrst_restart", 64'd0);

      // Randomized traffic against the stream model
      for (int i = 0; i < 64; i++)
         mem[i] = (($urandom % 16) == 0) ? HALT_W : {$urandom, $urandom};
      do_reset();
      m_pc    = 64'h0;
      m_valid = 1'b0;
      m_halt  = 1'b0;
      m_count = 32'd0;
      for (int c = 0; c < 600; c++) begin
         br  = (($urandom % 8) == 0);
         rdy = (($urandom % 4) != 0);
         tgt = 64'($urandom % 256);
         branch_taken  = br;
         branch_target = tgt;
         bus.id_ready  = rdy;
         #2;
         exp_v = m_valid && !m_halt && !br;
         chk("rnd_valid", 64'(bus.if_id_valid), 64'(exp_v));
         if (exp_v) begin
            chk("rnd_pc", bus.if_id_pc, m_pc);
            chk("rnd_instr", bus.if_id_instr, mem_word(m_pc));
         end
         chk("rnd_halted", 64'(halted), 64'(m_halt));
         chk("rnd_count", 64'(fetch_count), 64'(m_count));
         tick();
         if (br) begin
            m_pc    = {tgt[63:2], 2'b00};
            m_valid = 1'b1;
            m_halt  = 1'b0;
         end else if (m_halt) begin
            m_halt = 1'b1;
         end else if (!m_valid) begin
            m_valid = 1'b1;
         end else if (rdy) begin
            m_count = m_count + 32'd1;
            if (mem_word(m_pc) == HALT_W) begin
               m_halt  = 1'b1;
               m_valid = 1'b0;
            end else begin
               m_pc = m_pc + 64'd4;
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the memory read address.
- The memory returns data registered on the clock edge after the address is presented (1-cycle read latency); this block pairs each returned word with its PC.
- Presents the pair to decode with a valid/ready handshake, and handles stall, branch redirect, and halt.

Parameters:
- n, 64, datapath width of PC, addresses and instruction words.
- RESET_PC, 0, byte address of the first fetch after reset.
- HALT_INSTR, 64'h0, instruction encoding that stops fetching once accepted by decode.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- branch_taken  input  1  redirect request from the execute stage.
- branch_target  input  n  byte address of the redirect; bits [1:0] are ignored and treated as 0.
- id_ready  input  1  decode can accept the current output.
- imem_addr  output  n  word index to instruction memory, equal to selected PC >> 2 (combinational).
- imem_data  input  n  instruction memory read data; valid the cycle after its address.
- if_id_pc  output  n  byte PC of if_id_instr.
- if_id_instr  output  n  instruction word; wired directly from imem_data.
- if_id_valid  output  1  if_id_pc/if_id_instr are meaningful.
- halted  output  1  high while in the HALT state.
- fetch_count  output  32  number of instructions accepted by decode; wraps at 2^32.

Behaviour:
- Registers:
  - fetch_pc: next PC to issue.
  - resp_pc, resp_valid: the address issued last cycle, whose data is on imem_data now.
  - state: RUN or HALT.
  - fetch_count.
- Reset (rst_n=0 at a rising edge):
  - fetch_pc=RESET_PC, resp_pc=0, resp_valid=0, state=RUN, fetch_count=0.
  - Outputs during and after that edge: if_id_valid=0, halted=0, if_id_pc=0.
- if_id_pc=resp_pc. if_id_valid = resp_valid && state==RUN && !branch_taken.
- accept = if_id_valid && id_ready.
- RUN, priority order, evaluated each cycle:
  - 1. branch_taken:
    - imem_addr = target>>2.
    - At the edge: resp_pc<=target, resp_valid<=1, fetch_pc<=target+4.
    - The current response is squashed and not counted.
  - 2. Stall, when resp_valid && !id_ready:
    - imem_addr = resp_pc>>2, so memory re-reads the same word.
    - All registers hold. Output stays stable.
  - 3. Otherwise:
    - imem_addr = fetch_pc>>2.
    - At the edge: resp_pc<=fetch_pc, resp_valid<=1, fetch_pc<=fetch_pc+4.
    - If accept, then fetch_count<=fetch_count+1.
    - If accept && imem_data==HALT_INSTR, then state<=HALT and resp_valid<=0. The halt word itself is delivered and counted.
- HALT:
  - if_id_valid=0, halted=1, imem_addr = fetch_pc>>2 (don't-care read). Registers hold.
  - branch_taken performs the RUN redirect and sets state<=RUN, covering a halt fetched on a wrong path.
- Throughput: 1 instruction/cycle when unstalled. First valid output appears 1 cycle after reset release.
- Redirect penalty: the redirect cycle itself outputs nothing. The target instruction appears the following cycle.
- branch_taken together with !id_ready: redirect wins, and the stalled word is discarded.
- PC arithmetic is modulo 2^n with no overflow detection. The memory uses only the low index bits it needs.
- Reset asserted mid-stall or mid-redirect: the reset values take effect at the next edge unconditionally.

Decomposition:
- Shared package holds:
  - state encoding: RUN=1'b0, HALT=1'b1.
  - PC_STEP=4.
  - word-index shift WORD_SHIFT=2.
- No sub-module. The next-PC/address mux and the control logic stay in a single module.

Test Plan:
- Reset, RESET_PC=0, memory words 0..3 = A,B,C,D, id_ready=1:
  - if_id_valid rises 1 cycle after release.
  - Output sequence is (0,A), (4,B), (8,C), (12,D).
  - fetch_count=4 after 4 accepts.
- Stall: id_ready=0 for 3 cycles while (4,B) is presented:
  - imem_addr=1 throughout, and (4,B) is held.
  - Release gives (8,C) next, with no duplicate and no loss.
- Redirect: branch_taken=1 with target=0x40 while (8,C) is presented:
  - That cycle has if_id_valid=0 and imem_addr=0x10.
  - The next cycle presents (0x40, mem[16]).
  - fetch_count is not incremented for C.
- Redirect plus stall in the same cycle: the result matches the previous case, and the stalled word is never delivered.
- Halt: mem[2]=HALT_INSTR:
  - (8,HALT) is accepted, then halted=1 and if_id_valid=0 indefinitely.
  - A later branch_taken to 0x0 resumes with (0,A) and halted=0.
- Synchronous reset asserted mid-run:
  - Outputs clear only at the clock edge, not before.
  - Fetch restarts at RESET_PC and fetch_count returns to 0.
